// File: rtl/uart_rx.sv
// UART receiver: oversampled mid-bit sampling, 8N1 framing,
// one-entry holding register with valid/ready, error pulses.
module uart_rx #(
  parameter int  DW         = 8,
  parameter real CLOCK      = 100e6,
  parameter real BAUD_RATE  = 115200,
  parameter int  OVERSAMPLE = 16,
  parameter int  TICK_DIV   = $rtoi(CLOCK / (BAUD_RATE * OVERSAMPLE)),
  parameter int  TW         = $clog2(TICK_DIV + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs,
  input  logic          Rx,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          frame_err_o,
  output logic          overrun_o
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic          rx_m;
  logic          rx_s;
  logic [2:0]    state;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] shreg;
  logic          tick;
  logic          bit_end;
  logic          mid_start;
  logic          deliver;
  logic          stop_bad;

  assign tick      = (tcnt == TW'(TICK_DIV - 1));
  assign bit_end   = tick && (scnt == SW'(OVERSAMPLE - 1));
  assign mid_start = tick && (scnt == SW'(OVERSAMPLE / 2 - 1));
  assign deliver   = cs && (state == STOP) && bit_end && rx_s;
  assign stop_bad  = cs && (state == STOP) && bit_end && !rx_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      tcnt  <= '0;
      scnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else if (!cs) begin
      state <= IDLE;
      tcnt  <= '0;
      scnt  <= '0;
      bcnt  <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      unique case (state)
        IDLE: begin
          // restart the divider so ticks line up with the edge
          if (!rx_s) begin
            state <= START;
            tcnt  <= '0;
            scnt  <= '0;
          end
        end
        START: begin
          if (mid_start) begin
            scnt  <= '0;
            bcnt  <= '0;
            state <= rx_s ? IDLE : DATA;
          end else if (tick) begin
            scnt <= scnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            scnt        <= '0;
            shreg[bcnt] <= rx_s;
            bcnt        <= bcnt + 1'b1;
            if (bcnt == BW'(DW - 1)) state <= STOP;
          end else if (tick) begin
            scnt <= scnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            scnt  <= '0;
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else if (tick) begin
            scnt <= scnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // hold off while the line sits in break
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_bad;
      overrun_o   <= deliver && valid_o && !ready_i;
      if (deliver && (!valid_o || ready_i)) begin
        data_o  <= shreg;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
